// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with first-word-fall-through byte FIFO
//
// Receives frames on rxd, LSB first, and buffers each good byte in a small
// FWFT FIFO that drains over a valid/ready handshake.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit (8E1).
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bit/s (CLK_FREQ/BAUD must be >= 4)
//   FIFO_DEPTH  buffered bytes, power of two, >= 2
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rxd        asynchronous serial input, idles high
//   rx_data    byte at the FIFO head, meaningful while rx_valid=1
//   rx_valid   FIFO not empty
//   rx_ready   consumer accepts; pop on rx_valid & rx_ready
//   frame_err  one-cycle pulse: bad stop bit (or bad parity)
//   overrun    one-cycle pulse: byte dropped because the FIFO was full
//   busy       receiver is inside a frame
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  // The timer restarts at 0 on every transition, so a limit of N-1 means
  // "sample N cycles after entering the state".
  localparam logic [TW-1:0] HALF_LIM = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LIM = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic          rx_meta;
  logic          rxs;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  logic          push;
  logic          stop_err;
`ifdef UART_RX_PARITY_EN
  logic          par_err;
`endif

  // Two-flop synchroniser, preset to 1 so the line reads idle out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // START samples at half a bit; every later state samples a full bit after
  // the previous sample, which lands at the middle of each following bit.
  assign tick = (state == ST_START) ? (timer == HALF_LIM) : (timer == FULL_LIM);
  assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  assign push     = (state == ST_STOP) && tick && rxs && !par_err;
  assign stop_err = (state == ST_STOP) && tick && (!rxs || par_err);
`else
  assign push     = (state == ST_STOP) && tick && rxs;
  assign stop_err = (state == ST_STOP) && tick && !rxs;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= stop_err;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (!rxs) state <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            timer   <= '0;
            bit_idx <= '0;
            // A line back high at mid-start was a glitch, not a frame.
            state   <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick) begin
            timer   <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            timer   <= '0;
            par_err <= (rxs != ^shreg);
            state   <= ST_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            timer <= '0;
            state <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_BREAK: begin
          // Hold here until the line recovers so a stuck-low line yields one error.
          timer <= '0;
          if (rxs) state <= ST_IDLE;
        end
        default: begin
          timer <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // FWFT FIFO. Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        accept;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rx_valid = !empty;
  assign rx_data  = mem[rptr[AW-1:0]];
  assign pop      = rx_valid && rx_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can land there.
  assign accept   = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && full && !pop;
      if (accept) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int CPB   = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Frame-relative negedge index just before the stop-bit mid-sample edge:
  // 2 synchroniser flops + 1 idle detect + half bit, then one bit per CPB.
  localparam int STOP_PRE = (NBITS - 1) * CPB + 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;

  logic [7:0] model_q[$];
  int         exp_ov;

  uart_rx_fifo #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives one frame bit by bit from the negedge; rx_ready is high for the
  // single cycle whose index equals ready_cycle (-1 for never).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int ready_cycle, output logic v_pre, output logic v_post);
    logic [10:0] bits;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^b) ^ par_flip;
    bits[10] = stop_bit;
`else
    bits[9]  = stop_bit ^ (par_flip & 1'b0);
`endif
    v_pre  = 1'b0;
    v_post = 1'b0;
    for (int c = 0; c < NBITS * CPB; c++) begin
      @(negedge clk);
      if (c == STOP_PRE) v_pre = rx_valid;
      if (c == STOP_PRE + 1) v_post = rx_valid;
      rxd      = bits[c / CPB];
      rx_ready = (c == ready_cycle);
    end
  endtask

  // Model of a good frame arriving with no consumer activity.
  task automatic send_good(input logic [7:0] b);
    logic vp, vq;
    send_frame(b, 1'b1, 1'b0, -1, vp, vq);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ov++;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = model_q.pop_front();
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, e});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (model_q.size() > 0) pop_check(tag);
    check({tag, "_empty"}, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    logic       vp, vq;
    int         ov0, fe0, bad, n;
    logic [7:0] popped;

    reset    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    exp_ov   = 0;
    idle(3);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Idle line: nothing happens for 500 cycles.
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_valid || busy || frame_err || overrun) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single byte, exact latency, held until consumed.
    send_frame(8'hA5, 1'b1, 1'b0, -1, vp, vq);
    model_q.push_back(8'hA5);
    check("a5_pre_stop", {31'd0, vp}, 32'd0);
    check("a5_post_stop", {31'd0, vq}, 32'd1);
    idle(20);
    check("a5_hold_valid", {31'd0, rx_valid}, 32'd1);
    check("a5_hold_data", {24'd0, rx_data}, 32'hA5);
    drain("a5");

    // Five back-to-back bytes into a depth-4 FIFO.
    ov0 = ov_cnt;
    exp_ov = 0;
    for (int i = 1; i <= 5; i++) send_good(8'(i));
    idle(2);
    check("ovr_pulses", ov_cnt - ov0, exp_ov);
    drain("ovr");

    // Full FIFO with a pop landing on the stop-sample edge.
    ov0 = ov_cnt;
    exp_ov = 0;
    for (int i = 0; i < DEPTH; i++) send_good(8'($urandom_range(0, 255)));
    send_frame(8'h3C, 1'b1, 1'b0, STOP_PRE, vp, vq);
    popped = model_q.pop_front();
    model_q.push_back(8'h3C);
    idle(2);
    check("full_pop_ovr", ov_cnt - ov0, 0);
    drain("fullpop");

    // Bad stop bit followed by a held-low line.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0, -1, vp, vq);
    rxd = 1'b0;
    idle(40);
    rxd = 1'b1;
    idle(5);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_nopush", {31'd0, rx_valid}, 32'd0);
    send_good(8'h7E);
    drain("after_brk");

    // Short glitch on an idle line.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(20);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Reset in the middle of a frame, with a byte already buffered.
    send_good(8'h99);
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      rxd = (c < CPB) ? 1'b0 : c[0];
    end
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    model_q.delete();
    rxd = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(5);
    send_good(8'hC3);
    drain("after_rst");

    // Random bursts against the queue model.
    for (int r = 0; r < 5; r++) begin
      ov0 = ov_cnt;
      exp_ov = 0;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) send_good(8'($urandom_range(0, 255)));
      idle(2);
      check("rnd_ovr", ov_cnt - ov0, exp_ov);
      drain("rnd");
    end

`ifdef UART_RX_PARITY_EN
    fe0 = fe_cnt;
    send_frame(8'h0F, 1'b1, 1'b0, -1, vp, vq);
    model_q.push_back(8'h0F);
    drain("par_ok");
    send_frame(8'h0F, 1'b1, 1'b1, -1, vp, vq);
    idle(3);
    check("par_bad_ferr", fe_cnt - fe0, 1);
    check("par_bad_nopush", {31'd0, rx_valid}, 32'd0);
`endif

    check("never_both", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the board serial input `rxd`; the receive-side counterpart of the transmitter driving `txd`.
- Deserialises 8N1 frames, LSB first, and buffers received bytes in a small first-word-fall-through FIFO.
- Bytes leave the FIFO over a valid/ready handshake to the processor I/O logic.
- Flags framing errors and FIFO overruns as single-cycle pulses.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- FIFO_DEPTH, 4: number of buffered bytes; must be a power of two, >= 2.
- Derived: CLKS_PER_BIT = CLK_FREQ/BAUD, integer division; must be >= 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts; a pop occurs when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: bad stop bit (or parity, see below).
- overrun  output  1  one-cycle pulse: byte lost because the FIFO was full.
- busy  output  1  receiver is inside a frame (state not IDLE).

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FIFO empty; state=IDLE.
  - Both synchroniser flops=1, so the line reads as idle.
- Synchroniser: rxd passes through 2 flops; `rxs` below is the synchronised value. All sampling uses rxs.
- Bit timer: counts 0..CLKS_PER_BIT-1, reloaded on every state transition.
- IDLE:
  - On rxs=0, go to START and load the timer to sample at CLKS_PER_BIT/2.
- START:
  - At mid-bit, rxs=0: go to DATA with bit index 0 and timer period CLKS_PER_BIT.
  - At mid-bit, rxs=1: glitch; return to IDLE with no flags.
- DATA:
  - At each mid-bit, shift rxs into bit[index]; LSB arrives first.
  - After index 7, go to STOP.
- STOP, evaluated at mid-bit:
  - rxs=1: push the byte and go to IDLE.
  - rxs=0: discard the byte, pulse frame_err, go to BREAK.
- BREAK:
  - Wait for rxs=1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Latency:
  - rx_valid rises on the cycle after the stop-bit mid-sample, provided the FIFO was empty.
  - rx_data is updated on that same edge.
- FIFO:
  - First-word-fall-through; rx_data always shows the head entry.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full is detected by the MSB differing with the remaining bits equal.
- Push while full:
  - Without a pop in the same cycle: byte dropped, overrun pulses 1 cycle, contents unchanged.
  - With a pop in the same cycle: push accepted, no overrun, occupancy unchanged.
- Push while empty with a pop in the same cycle: impossible, since rx_valid=0 so no pop occurs.
- Pop with no push: occupancy decrements; rx_valid falls when occupancy reaches 0.
- frame_err and overrun are never asserted in the same cycle; a framing error pushes nothing.
- Reset mid-frame: the partial byte is lost, the FIFO is cleared, and the block returns to IDLE immediately (asynchronously).
- A start bit arriving during the cycle that returns to IDLE is caught on the next cycle; this slip is inside the half-bit margin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; frame becomes 8E1.
  - Sampled bit must equal the XOR of the 8 data bits (even parity).
  - Mismatch is recorded; at a good STOP the byte is discarded and frame_err pulses instead of a push.
  - A bad stop bit still enters BREAK.
- Not defined:
  - No PARITY state; 8N1 only. Parity logic is absent from the netlist.

Test Plan:
- Setup for all scenarios: CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10.
- Idle line after release of reset=0 -> rx_valid=0, busy=0, no flags for 500 cycles.
- Send 0xA5 with rx_ready=0 -> rx_valid=1 with rx_data=0xA5 within 1 cycle of the stop-bit mid-sample; holds until rx_ready=1, then rx_valid=0 the next cycle.
- Send 0x01,0x02,0x03,0x04,0x05 back-to-back with rx_ready=0 (depth 4):
  - Exactly one overrun pulse during byte 5.
  - Then pop with rx_ready=1 -> 0x01..0x04 in order, then rx_valid=0.
- Fill the FIFO, then send 0x3C while holding rx_ready=1 at its stop sample -> no overrun, 0x3C delivered last.
- Send 0x55 with the stop bit forced to 0, then hold rxd low 40 cycles -> one frame_err pulse, no push. Then send 0x7E -> received correctly.
- 3-cycle low glitch on idle rxd -> returns to IDLE, no push, no flags. Separately, assert reset low mid-byte -> all outputs at reset values; the next 0xC3 is received intact.
- (UART_RX_PARITY_EN) 0x0F with parity 0 -> delivered. 0x0F with parity 1 -> frame_err, nothing pushed.
